// File: rtl/fetch_req_ctrl_if.sv
// Fetch request/response handshake between the fetch sequencer (master) and the icache (slave).
interface fetch_req_ctrl_if #(
  parameter int EPOCH_W = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_pc;
  logic [EPOCH_W-1:0] req_epoch;
  logic               rsp_valid;
  logic               rsp_accept;
  logic               rsp_drop;
  logic [31:0]        fetch_pc;

  modport master (
    output req_valid, req_pc, req_epoch, rsp_accept, rsp_drop, fetch_pc,
    input  req_ready, rsp_valid
  );

  modport slave (
    input  req_valid, req_pc, req_epoch, rsp_accept, rsp_drop, fetch_pc,
    output req_ready, rsp_valid
  );
endinterface

// File: rtl/fetch_req_ctrl.sv
// Fetch request sequencer: one icache request in flight, flush/predict/sequential next-PC, ADEF on misaligned PC.
// Optional FETCH_REQ_PERF_CNT_EN adds saturating request/drop counters; otherwise the perf ports are tied to 0.
module fetch_req_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          EPOCH_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic                 stall,
  input  logic                 iuncache,
  input  logic                 pred_taken,
  input  logic [31:0]          pred_pc,
  fetch_req_ctrl_if.master     fetch,
  output logic                 exc_valid,
  output logic [6:0]           exc_cause,
  output logic [31:0]          perf_req_cnt,
  output logic [31:0]          perf_drop_cnt
);

  localparam logic [6:0]         EXCEPTION_NOP  = 7'h00;
  localparam logic [6:0]         EXCEPTION_ADEF = 7'h08;
  localparam logic [EPOCH_W-1:0] EPOCH_ONE      = EPOCH_W'(1);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    EXC   = 3'd4
  } state_t;

  state_t             state;
  logic [31:0]        pc_q;
  logic [31:0]        inflight_pc;
  logic [EPOCH_W-1:0] epoch_q;

  logic        req_fire;
  logic        rsp_accept;
  logic        rsp_drop;
  logic [31:0] seq_pc;

  always_comb begin
    fetch.req_valid = (state == REQ) && !flush && !stall && (pc_q[1:0] == 2'b00);
    req_fire        = fetch.req_valid && fetch.req_ready;
    rsp_accept      = (state == WAIT) && fetch.rsp_valid && !flush;
    // A response racing a flush in WAIT is stale, as is anything that lands in DRAIN.
    rsp_drop        = fetch.rsp_valid && (((state == WAIT) && flush) || (state == DRAIN));
    seq_pc          = inflight_pc + (iuncache ? 32'd4 : 32'd8);
  end

  assign fetch.req_pc     = pc_q;
  assign fetch.req_epoch  = epoch_q;
  assign fetch.rsp_accept = rsp_accept;
  assign fetch.rsp_drop   = rsp_drop;
  assign fetch.fetch_pc   = rsp_accept ? inflight_pc : 32'd0;
  assign exc_valid        = (state == EXC);
  assign exc_cause        = (state == EXC) ? EXCEPTION_ADEF : EXCEPTION_NOP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      epoch_q     <= '0;
      inflight_pc <= '0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (flush) begin
            pc_q    <= flush_pc;
            epoch_q <= epoch_q + EPOCH_ONE;
          end else if (pc_q[1:0] != 2'b00) begin
            state <= EXC;
          end else if (req_fire) begin
            inflight_pc <= pc_q;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            pc_q    <= flush_pc;
            epoch_q <= epoch_q + EPOCH_ONE;
            state   <= fetch.rsp_valid ? REQ : DRAIN;
          end else if (fetch.rsp_valid) begin
            pc_q  <= pred_taken ? pred_pc : seq_pc;
            state <= REQ;
          end
        end
        DRAIN: begin
          if (flush) begin
            pc_q    <= flush_pc;
            epoch_q <= epoch_q + EPOCH_ONE;
          end
          if (fetch.rsp_valid) state <= REQ;
        end
        EXC: begin
          if (flush) begin
            pc_q    <= flush_pc;
            epoch_q <= epoch_q + EPOCH_ONE;
            state   <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_REQ_PERF_CNT_EN
  logic [31:0] req_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (req_fire && (req_cnt_q != 32'hffffffff)) req_cnt_q <= req_cnt_q + 32'd1;
      if (rsp_drop && (drop_cnt_q != 32'hffffffff)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_req_cnt  = req_cnt_q;
  assign perf_drop_cnt = drop_cnt_q;
`else
  assign perf_req_cnt  = 32'd0;
  assign perf_drop_cnt = 32'd0;
`endif

endmodule
